seq_alu: RTL and testbench

//  Parametrised, handshaked successor to the 5-bit combinational ALU; four ops
//  (multiply, compare, add, shifted subtract) on WIDTH-bit operands. Multiply is
//  a WIDTH-cycle shift-add engine giving the full 2*WIDTH product; other ops take
//  one cycle. Sits between the datapath register file and the result/flag latch.

---
 rtl/seq_alu.sv | 180 ++++++++++++++++++
 tb/tb_seq_alu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked four-op ALU (mul, cmp, add, shifted sub) on WIDTH-bit operands.
// Multiply runs a WIDTH-cycle shift-add engine producing the full 2*WIDTH product;
// cmp/add/sub complete on the accepting edge and report done one cycle later.
//
// Handshake: a request is the pair (start, busy). start is accepted on a rising
// edge only when busy=0; op/x/y are sampled on that same edge. start while busy=1
// is dropped, not queued. done pulses for exactly one cycle when f/hi/cout/overflow
// carry a fresh result; those outputs then hold until the next result is written.
// busy is low in the done cycle, so a new request may be issued back-to-back.
module seq_alu #(
    parameter int WIDTH     = 5,
    parameter int SUB_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] hi,
    output logic             cout,
    output logic             overflow,
    output logic             dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    // Single-cycle datapath values computed straight from the live operands.
    logic [WIDTH-1:0]   y_sh;
    logic [WIDTH-1:0]   neg_y;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;
    logic [2*WIDTH-1:0] prod_next;

    // Operand arithmetic: add, two's-complement of the shifted y, and one multiply step.
    always_comb begin
        y_sh      = y << SUB_SHIFT;
        neg_y     = ~y_sh + W_ONE;
        add_sum   = {1'b0, x} + {1'b0, y};
        sub_sum   = {1'b0, x} + {1'b0, neg_y};
        prod_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Next-state and result logic for the IDLE/MUL controller.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        f_d      = f_q;
        hi_d     = hi_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MUL: begin
                            state_d  = S_MUL;
                            busy_d   = 1'b1;
                            cnt_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, x};
                            mplier_d = y;
                            acc_d    = '0;
                        end
                        OP_CMP: begin
                            f_d    = '0;
                            hi_d   = '0;
                            cout_d = (x > y);
                            ovf_d  = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_ADD: begin
                            {cout_d, f_d} = add_sum;
                            hi_d   = '0;
                            // Overflow judged on the freshly computed sum, not f_q.
                            ovf_d  = (x[WIDTH-1] == y[WIDTH-1]) &&
                                     (add_sum[WIDTH-1] != x[WIDTH-1]);
                            done_d = 1'b1;
                        end
                        OP_SUB: begin
                            {cout_d, f_d} = sub_sum;
                            hi_d   = '0;
                            ovf_d  = (x[WIDTH-1] == neg_y[WIDTH-1]) &&
                                     (sub_sum[WIDTH-1] != x[WIDTH-1]);
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                // One multiplier bit per cycle, LSB first; multiplicand walks left.
                acc_d    = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    {hi_d, f_d} = prod_next;
                    cout_d  = |prod_next[2*WIDTH-1:WIDTH];
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, engine and result registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            f_q      <= '0;
            hi_q     <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            f_q      <= f_d;
            hi_q     <= hi_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign f         = f_q;
    assign hi        = hi_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu (WIDTH=5, SUB_SHIFT=2)
// against an arithmetic reference model.
module tb_seq_alu;

    localparam int W  = 5;
    localparam int SS = 2;
    localparam int M  = 1 << W;
    localparam int RW = 2 * W + 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] f;
    logic [W-1:0] hi;
    logic         cout;
    logic         overflow;
    logic         dbg_state;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] exp_q[$];

    seq_alu #(.WIDTH(W), .SUB_SHIFT(SS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .f         (f),
        .hi        (hi),
        .cout      (cout),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic int to_signed(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Reference: {hi, f, cout, overflow} from plain integer arithmetic.
    function automatic logic [RW-1:0] model(input logic [1:0] o, input int a, input int b);
        int p, s, n, ss;
        logic [W-1:0] rf, rh;
        logic rc, rv;
        rf = '0; rh = '0; rc = 1'b0; rv = 1'b0;
        case (o)
            2'b00: begin
                p  = a * b;
                rf = W'(p % M);
                rh = W'(p / M);
                rc = (p >= M);
            end
            2'b01: rc = (a > b);
            2'b10: begin
                s  = a + b;
                rf = W'(s % M);
                rc = (s >= M);
                ss = to_signed(a) + to_signed(b);
                rv = (ss > M / 2 - 1) || (ss < -(M / 2));
            end
            default: begin
                n  = (M - ((b * (1 << SS)) % M)) % M;
                s  = a + n;
                rf = W'(s % M);
                rc = (s >= M);
                ss = to_signed(a) + to_signed(n);
                rv = (ss > M / 2 - 1) || (ss < -(M / 2));
            end
        endcase
        return {rh, rf, rc, rv};
    endfunction

    // Driver: issue one request, wait for done, check latency/result/hold.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name);
        logic [RW-1:0] e;
        int lat;
        int exp_lat;
        exp_lat = (o == 2'b00) ? W + 1 : 1;
        exp_q.push_back(model(o, int'(a), int'(b)));
        start = 1'b1; op = o; x = a; y = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); x = W'($urandom); y = W'($urandom);
        lat = 1;
        if (o == 2'b00) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL %s busy_after_start got=%b exp=1", name, busy);
            end
        end
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL %s done_timeout got=%b exp=1", name, done);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat);
        end
        checks++;
        if ({hi, f, cout, overflow} !== e) begin
            errors++;
            $display("FAIL %s result got hi=%b f=%b c=%b v=%b exp hi=%b f=%b c=%b v=%b",
                     name, hi, f, cout, overflow, e[RW-1 -: W], e[W+1 -: W], e[1], e[0]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s busy_in_done got=%b exp=0", name, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || {hi, f, cout, overflow} !== e) begin
            errors++;
            $display("FAIL %s hold got done=%b res=%b exp done=0 res=%b",
                     name, done, {hi, f, cout, overflow}, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, hi, f, cout, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {busy, done, hi, f, cout, overflow});
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(2'b00, 5'd7,      5'd5,      "mul_7x5");
        run_op(2'b00, 5'd31,     5'd31,     "mul_31x31");
        run_op(2'b10, 5'b01111, 5'b00001, "add_ovf");
        run_op(2'b10, 5'b11111, 5'b00001, "add_carry");
        run_op(2'b11, 5'b00011, 5'b00001, "sub_neg");
        run_op(2'b11, 5'b10000, 5'b00001, "sub_ovf");
        run_op(2'b11, 5'b00101, 5'b01000, "sub_n_zero");
        run_op(2'b01, 5'b00010, 5'b00001, "cmp_gt");
        run_op(2'b01, 5'b10101, 5'b10101, "cmp_eq");
        run_op(2'b00, 5'd0,      5'd31,     "mul_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op(2'($urandom), W'($urandom), W'($urandom), "random");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignore_busy();
        logic [RW-1:0] e;
        int lat;
        int extra;
        e = model(2'b00, 7, 5);
        start = 1'b1; op = 2'b00; x = 5'd7; y = 5'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        @(posedge clk); #1; lat++;
        start = 1'b1; op = 2'b10; x = 5'd15; y = 5'd1;
        @(posedge clk); #1; lat++;
        start = 1'b0; x = 5'd3; y = 5'd9;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== W + 1 || done !== 1'b1) begin
            errors++; $display("FAIL ignore_busy latency got=%0d exp=%0d", lat, W + 1);
        end
        checks++;
        if ({hi, f, cout, overflow} !== e) begin
            errors++; $display("FAIL ignore_busy result got=%b exp=%b", {hi, f, cout, overflow}, e);
        end
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL ignore_busy extra_done got=%0d exp=0", extra);
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        run_op(2'b10, 5'b01111, 5'b00001, "pre_reset_add");
        start = 1'b1; op = 2'b00; x = 5'd31; y = 5'd31;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, f, cout, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_mid_mul got=%b exp=0", {busy, done, hi, f, cout, overflow});
        end
        #4 rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || {hi, f, cout, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_mid_mul after got seen=%0d res=%b exp 0", seen, {hi, f, cout, overflow});
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] e_mul, e_add;
        int lat;
        e_mul = model(2'b00, 13, 11);
        e_add = model(2'b10, 9, 9);
        start = 1'b1; op = 2'b00; x = 5'd13; y = 5'd11;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if ({hi, f, cout, overflow} !== e_mul || done !== 1'b1) begin
            errors++; $display("FAIL b2b_mul got=%b exp=%b", {hi, f, cout, overflow}, e_mul);
        end
        start = 1'b1; op = 2'b10; x = 5'd9; y = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || {hi, f, cout, overflow} !== e_add) begin
            errors++;
            $display("FAIL b2b_add got done=%b res=%b exp done=1 res=%b",
                     done, {hi, f, cout, overflow}, e_add);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
